// File: rtl/rtype_exec_sequencer.sv
// rtl/rtype_exec_sequencer.sv - multi-cycle fetch/decode/execute/writeback sequencer for R-type ops
// Optional trap-to-HALT on illegal instructions is enabled by defining ILLEGAL_TRAP_EN.
module rtype_exec_sequencer #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [3:0]      alu_control,
  output logic            alu_en,
  output logic            write_on_register,
  output logic [XLEN-1:0] pc,
  output logic            busy,
  output logic [31:0]     retired,
  output logic            illegal
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] instr_q;
  logic        legal_q;
  logic        dec_legal;
  logic [3:0]  dec_ctrl;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;

  assign opcode = instr_q[6:0];
  assign func3  = instr_q[14:12];
  assign func7  = instr_q[31:25];

  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = 4'b0000;
    if (opcode == 7'b0110011) begin
      if (func7 == 7'd0) begin
        dec_legal = 1'b1;
        case (func3)
          3'd0:    dec_ctrl = 4'b0100;
          3'd1:    dec_ctrl = 4'b0001;
          3'd2:    dec_ctrl = 4'b1010;
          3'd3:    dec_ctrl = 4'b1001;
          3'd4:    dec_ctrl = 4'b1000;
          3'd5:    dec_ctrl = 4'b0010;
          3'd6:    dec_ctrl = 4'b0111;
          default: dec_ctrl = 4'b0110;
        endcase
      end else if (func7 == 7'd32 && (func3 == 3'd0 || func3 == 3'd5)) begin
        dec_legal = 1'b1;
        dec_ctrl  = (func3 == 3'd0) ? 4'b0101 : 4'b0011;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (run_en) state_nxt = FETCH;
      FETCH:     if (imem_ack) state_nxt = DECODE;
`ifdef ILLEGAL_TRAP_EN
      DECODE:    state_nxt = dec_legal ? EXECUTE : HALT;
`else
      DECODE:    state_nxt = EXECUTE;
`endif
      EXECUTE:   state_nxt = WRITEBACK;
      WRITEBACK: state_nxt = run_en ? FETCH : IDLE;
      HALT:      state_nxt = HALT;
      default:   state_nxt = IDLE;
    endcase
  end

  assign imem_req          = (state == FETCH);
  assign imem_addr         = pc;
  assign busy              = (state != IDLE) && (state != HALT);
  assign alu_en            = (state == EXECUTE) && legal_q;
  assign write_on_register = (state == WRITEBACK) && legal_q && (rd_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      retired     <= 32'd0;
      instr_q     <= 32'd0;
      rs1_addr    <= 5'd0;
      rs2_addr    <= 5'd0;
      rd_addr     <= 5'd0;
      alu_control <= 4'd0;
      legal_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack)
        instr_q <= imem_rdata;
      if (state == DECODE) begin
        rs1_addr    <= instr_q[19:15];
        rs2_addr    <= instr_q[24:20];
        rd_addr     <= instr_q[11:7];
        alu_control <= dec_ctrl;
        legal_q     <= dec_legal;
      end
      // An illegal NOP still advances pc; only a write bumps the retire count.
      if (state == WRITEBACK) begin
        pc <= pc + XLEN'(PC_STEP);
        if (write_on_register)
          retired <= retired + 32'd1;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (reset)
      illegal_q <= 1'b0;
    else if (state == DECODE && !dec_legal)
      illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_rtype_exec_sequencer.sv
// tb/tb_rtype_exec_sequencer.sv - directed self-checking bench for rtype_exec_sequencer
module tb_rtype_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_control;
  logic        alu_en;
  logic        write_on_register;
  logic [31:0] pc;
  logic        busy;
  logic [31:0] retired;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  rtype_exec_sequencer dut (
    .clk(clk), .reset(reset), .run_en(run_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_control(alu_control), .alu_en(alu_en), .write_on_register(write_on_register),
    .pc(pc), .busy(busy), .retired(retired), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge after WRITEBACK.
  task automatic do_instr(input string tag, input logic [31:0] ins, input int waits,
                          input logic exp_en, input logic exp_wr, input logic [3:0] exp_ctrl);
    check({tag, ".req"}, 32'(imem_req), 32'd1);
    check({tag, ".addr"}, imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check({tag, ".req_hold"}, 32'(imem_req), 32'd1);
      check({tag, ".addr_hold"}, imem_addr, exp_pc);
      check({tag, ".no_alu_en"}, 32'(alu_en), 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'b0;
    check({tag, ".dec_busy"}, 32'(busy), 32'd1);
    check({tag, ".dec_alu_en"}, 32'(alu_en), 32'd0);
    @(negedge clk);
    check({tag, ".alu_en"}, 32'(alu_en), 32'(exp_en));
    check({tag, ".alu_control"}, 32'(alu_control), 32'(exp_ctrl));
    check({tag, ".ex_wr"}, 32'(write_on_register), 32'd0);
    @(negedge clk);
    check({tag, ".wr"}, 32'(write_on_register), 32'(exp_wr));
    check({tag, ".wb_alu_en"}, 32'(alu_en), 32'd0);
    if (exp_wr) exp_ret = exp_ret + 32'd1;
    exp_pc = exp_pc + 32'd4;
    @(negedge clk);
    check({tag, ".pc"}, pc, exp_pc);
    check({tag, ".retired"}, retired, exp_ret);
    check({tag, ".next_req"}, 32'(imem_req), 32'(run_en));
  endtask

  logic [31:0] stream_ins [9];
  logic [3:0]  stream_ctl [9];

  initial begin
    reset = 1'b1; run_en = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    exp_pc = 32'd0; exp_ret = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.pc", pc, 32'd0);
    check("rst.retired", retired, 32'd0);
    check("rst.req", 32'(imem_req), 32'd0);
    check("rst.alu_control", 32'(alu_control), 32'd0);
    check("rst.wr", 32'(write_on_register), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);

    // add x3,x1,x2 with zero-wait memory
    run_en = 1'b1;
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'h002081B3;
    check("add.addr", imem_addr, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check("add.alu_en", 32'(alu_en), 32'd1);
    check("add.alu_control", 32'(alu_control), 32'b0100);
    check("add.rd", 32'(rd_addr), 32'd3);
    check("add.rs1", 32'(rs1_addr), 32'd1);
    check("add.rs2", 32'(rs2_addr), 32'd2);
    @(negedge clk);
    check("add.wr", 32'(write_on_register), 32'd1);
    check("add.alu_en_off", 32'(alu_en), 32'd0);
    @(negedge clk);
    check("add.wr_off", 32'(write_on_register), 32'd0);
    check("add.pc", pc, 32'd4);
    check("add.retired", retired, 32'd1);
    check("add.refetch_addr", imem_addr, 32'd4);
    exp_pc = 32'd4; exp_ret = 32'd1;

    // sub/sll/slt/sltu/xor/srl/sra/or/and
    stream_ins[0] = enc(7'd32, 3'd0, 5'd5, 5'd6, 5'd7); stream_ctl[0] = 4'b0101;
    stream_ins[1] = enc(7'd0,  3'd1, 5'd5, 5'd6, 5'd7); stream_ctl[1] = 4'b0001;
    stream_ins[2] = enc(7'd0,  3'd2, 5'd5, 5'd6, 5'd7); stream_ctl[2] = 4'b1010;
    stream_ins[3] = enc(7'd0,  3'd3, 5'd5, 5'd6, 5'd7); stream_ctl[3] = 4'b1001;
    stream_ins[4] = enc(7'd0,  3'd4, 5'd5, 5'd6, 5'd7); stream_ctl[4] = 4'b1000;
    stream_ins[5] = enc(7'd0,  3'd5, 5'd5, 5'd6, 5'd7); stream_ctl[5] = 4'b0010;
    stream_ins[6] = enc(7'd32, 3'd5, 5'd5, 5'd6, 5'd7); stream_ctl[6] = 4'b0011;
    stream_ins[7] = enc(7'd0,  3'd6, 5'd5, 5'd6, 5'd7); stream_ctl[7] = 4'b0111;
    stream_ins[8] = enc(7'd0,  3'd7, 5'd5, 5'd6, 5'd7); stream_ctl[8] = 4'b0110;
    for (int k = 0; k < 9; k++)
      do_instr($sformatf("stream%0d", k), stream_ins[k], 0, 1'b1, 1'b1, stream_ctl[k]);

    // slow memory, then rd=x0, then func7=32 with func3=1 (illegal)
    do_instr("wait5", enc(7'd0, 3'd7, 5'd9, 5'd1, 5'd2), 5, 1'b1, 1'b1, 4'b0110);
    do_instr("rd0", enc(7'd0, 3'd0, 5'd0, 5'd1, 5'd2), 0, 1'b1, 1'b0, 4'b0100);

`ifdef ILLEGAL_TRAP_EN
    imem_ack = 1'b1;
    imem_rdata = 32'h00000013;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check("trap.illegal", 32'(illegal), 32'd1);
    check("trap.busy", 32'(busy), 32'd0);
    check("trap.alu_en", 32'(alu_en), 32'd0);
    repeat (3) @(negedge clk);
    check("trap.pc_frozen", pc, exp_pc);
    check("trap.req", 32'(imem_req), 32'd0);
    check("trap.still_busy0", 32'(busy), 32'd0);
`else
    do_instr("addi_nop", 32'h00000013, 0, 1'b0, 1'b0, 4'b0000);
    check("nop.illegal", 32'(illegal), 32'd0);
    do_instr("sll_f7", enc(7'd32, 3'd1, 5'd4, 5'd1, 5'd2), 0, 1'b0, 1'b0, 4'b0000);
`endif

    // reset during EXECUTE aborts the instruction
    reset = 1'b1; run_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_pc = 32'd0; exp_ret = 32'd0;
    run_en = 1'b1;
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = enc(7'd0, 3'd0, 5'd8, 5'd1, 5'd2);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check("abort.in_exec", 32'(alu_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_en = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.pc", pc, 32'd0);
    check("abort.wr", 32'(write_on_register), 32'd0);
    check("abort.retired", retired, 32'd0);
    check("abort.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    check("abort.wr_late", 32'(write_on_register), 32'd0);

    // run_en dropped in DECODE lets the instruction finish, then IDLE
    run_en = 1'b1;
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = enc(7'd0, 3'd6, 5'd10, 5'd1, 5'd2);
    @(negedge clk);
    imem_ack = 1'b0;
    run_en = 1'b0;
    check("drop.dec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("drop.alu_en", 32'(alu_en), 32'd1);
    check("drop.alu_control", 32'(alu_control), 32'b0111);
    @(negedge clk);
    check("drop.wr", 32'(write_on_register), 32'd1);
    @(negedge clk);
    check("drop.busy", 32'(busy), 32'd0);
    check("drop.req", 32'(imem_req), 32'd0);
    check("drop.pc", pc, 32'd4);
    check("drop.retired", retired, 32'd1);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("drop.ack_ignored", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
